// File: rtl/decode_pkg.sv
// ============================================================================
// Module      : decode_pkg
// Description : Opcode constants, ALU operation codes and the decoded control
//               bundle shared by the decode stage and its decode logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decode_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    // The lower half is indexed by funct3; the upper half is the MUL/DIV family.
    // SUB/SRA share ALU_ADD/ALU_SR because the base half has only eight codes.
    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SLL    = 4'd1,
        ALU_SLT    = 4'd2,
        ALU_SLTU   = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SR     = 4'd5,
        ALU_OR     = 4'd6,
        ALU_AND    = 4'd7,
        ALU_MUL    = 4'd8,
        ALU_MULH   = 4'd9,
        ALU_MULHSU = 4'd10,
        ALU_MULHU  = 4'd11,
        ALU_DIV    = 4'd12,
        ALU_DIVU   = 4'd13,
        ALU_REM    = 4'd14,
        ALU_REMU   = 4'd15
    } aluop_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        aluop_e      aluOp;
        logic        memWrite;
        logic        regWrite;
        logic        aluSrc;
        logic        memToReg;
        logic        branch;
        logic        jump;
        logic        illegal;
    } ctrl_t;

    function automatic aluop_e alu_base(input logic [2:0] funct3);
        return aluop_e'({1'b0, funct3});
    endfunction

endpackage

`default_nettype wire

// File: rtl/decode_logic.sv
// ============================================================================
// Module      : decode_logic
// Description : Purely combinational RV32 subset decoder (instr -> ctrl_t).
//               DECODE_RV32M_EN enables the MUL/DIV family (funct7 0000001).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_logic
    import decode_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_illegal;
    ctrl_t      w_ctrl;

    assign w_opcode = instr_i[6:0];
    assign w_funct3 = instr_i[14:12];
    assign w_funct7 = instr_i[31:25];

    always_comb begin
        w_ctrl     = '0;
        w_illegal  = 1'b0;
        w_ctrl.rd  = instr_i[11:7];
        w_ctrl.rs1 = instr_i[19:15];
        w_ctrl.rs2 = instr_i[24:20];
        w_ctrl.aluOp = ALU_ADD;

        case (w_opcode)
            OPC_LOAD: begin
                w_ctrl.imm      = {{20{instr_i[31]}}, instr_i[31:20]};
                w_ctrl.regWrite = 1'b1;
                w_ctrl.memToReg = 1'b1;
            end
            OPC_STORE: begin
                w_ctrl.imm      = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
                w_ctrl.memWrite = 1'b1;
            end
            OPC_OP: begin
                w_ctrl.aluSrc   = 1'b1;
                w_ctrl.regWrite = 1'b1;
                case (w_funct7)
                    F7_BASE: w_ctrl.aluOp = alu_base(w_funct3);
                    F7_ALT: begin
                        if (w_funct3 == 3'b000 || w_funct3 == 3'b101)
                            w_ctrl.aluOp = alu_base(w_funct3);
                        else
                            w_illegal = 1'b1;
                    end
`ifdef DECODE_RV32M_EN
                    F7_MULDIV: w_ctrl.aluOp = aluop_e'({1'b1, w_funct3});
`endif
                    default: w_illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                w_ctrl.imm      = {{20{instr_i[31]}}, instr_i[31:20]};
                w_ctrl.regWrite = 1'b1;
                w_ctrl.aluOp    = alu_base(w_funct3);
            end
            OPC_BRANCH: begin
                w_ctrl.imm    = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                 instr_i[30:25], instr_i[11:8], 1'b0};
                w_ctrl.branch = 1'b1;
                w_ctrl.aluSrc = 1'b1;
            end
            OPC_LUI: begin
                w_ctrl.imm      = {instr_i[31:12], 12'b0};
                w_ctrl.regWrite = 1'b1;
            end
            OPC_JAL: begin
                w_ctrl.imm      = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                   instr_i[20], instr_i[30:21], 1'b0};
                w_ctrl.regWrite = 1'b1;
                w_ctrl.jump     = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase

        if (instr_i[1:0] != 2'b11)
            w_illegal = 1'b1;

        if (w_illegal) begin
            w_ctrl.regWrite = 1'b0;
            w_ctrl.memWrite = 1'b0;
            w_ctrl.branch   = 1'b0;
            w_ctrl.jump     = 1'b0;
        end
        w_ctrl.illegal = w_illegal;

        if (w_ctrl.rd == 5'd0)
            w_ctrl.regWrite = 1'b0;
    end

    assign ctrl_o = w_ctrl;

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// Module      : decode_stage
// Description : Decode pipeline stage with output + skid register and a
//               saturating illegal-instruction counter. DECODE_RV32M_EN
//               (in decode_logic) enables MUL/DIV decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage
    import decode_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output ctrl_t            out_ctrl,
    output logic [CNT_W-1:0] illegal_cnt
);

    ctrl_t             w_dec_ctrl;
    logic              w_accept;
    logic              w_deliver;

    logic              out_valid_q,  out_valid_d;
    ctrl_t             out_ctrl_q,   out_ctrl_d;
    logic [PC_W-1:0]   out_pc_q,     out_pc_d;
    logic              skid_valid_q, skid_valid_d;
    ctrl_t             skid_ctrl_q,  skid_ctrl_d;
    logic [PC_W-1:0]   skid_pc_q,    skid_pc_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;

    decode_logic u_decode_logic (
        .instr_i (in_instr),
        .ctrl_o  (w_dec_ctrl)
    );

    assign w_accept  = in_valid && !skid_valid_q;
    assign w_deliver = out_valid_q && out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_ctrl_d   = out_ctrl_q;
        out_pc_d     = out_pc_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_pc_d    = skid_pc_q;
        cnt_d        = cnt_q;

        if (w_deliver && out_ctrl_q.illegal && !(&cnt_q))
            cnt_d = cnt_q + 1'b1;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || w_deliver) begin
            // Skid entry is older than anything offered now, so it drains first.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_ctrl_d   = skid_ctrl_q;
                out_pc_d     = skid_pc_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = w_accept;
                if (w_accept) begin
                    out_ctrl_d = w_dec_ctrl;
                    out_pc_d   = in_pc;
                end
            end
        end else if (w_accept) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = w_dec_ctrl;
            skid_pc_d    = in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_ctrl_q   <= '0;
            out_pc_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_pc_q    <= '0;
            cnt_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_ctrl_q   <= out_ctrl_d;
            out_pc_q     <= out_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_pc_q    <= skid_pc_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready    = !skid_valid_q;
    assign out_valid   = out_valid_q;
    assign out_ctrl    = out_ctrl_q;
    assign out_pc      = out_pc_q;
    assign illegal_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// Module      : tb_decode_stage
// Description : Directed self-checking bench for decode_stage; expected
//               values are hand-decoded. Honours DECODE_RV32M_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_stage;
    import decode_pkg::*;

    localparam int PC_W  = 32;
    localparam int CNT_W = 8;
    localparam int NVEC  = 13;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [31:0]      in_instr  = '0;
    logic [PC_W-1:0]  in_pc     = '0;
    logic             flush     = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [PC_W-1:0]  out_pc;
    ctrl_t            out_ctrl;
    logic [CNT_W-1:0] illegal_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    logic [31:0] vec_instr [NVEC];
    ctrl_t       vec_ctrl  [NVEC];

    decode_stage #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_ctrl    (out_ctrl),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [PC_W-1:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    // flags = {memWrite, regWrite, aluSrc, memToReg, branch, jump, illegal}
    function automatic ctrl_t mk(input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [31:0] imm,
                                 input logic [3:0] alu, input logic [6:0] flags);
        ctrl_t c;
        c.rd       = rd;
        c.rs1      = rs1;
        c.rs2      = rs2;
        c.imm      = imm;
        c.aluOp    = aluop_e'(alu);
        c.memWrite = flags[6];
        c.regWrite = flags[5];
        c.aluSrc   = flags[4];
        c.memToReg = flags[3];
        c.branch   = flags[2];
        c.jump     = flags[1];
        c.illegal  = flags[0];
        return c;
    endfunction

    initial begin
        vec_instr[0]  = 32'h00812283; vec_ctrl[0]  = mk(5,  2, 8,  32'd8,        0, 7'b0101000); // lw x5,8(x2)
        vec_instr[1]  = 32'hFE512E23; vec_ctrl[1]  = mk(28, 2, 5,  32'hFFFFFFFC, 0, 7'b1000000); // sw x5,-4(x2)
        vec_instr[2]  = 32'h003100B3; vec_ctrl[2]  = mk(1,  2, 3,  32'd0,        0, 7'b0110000); // add x1,x2,x3
        vec_instr[3]  = 32'h123453B7; vec_ctrl[3]  = mk(7,  8, 3,  32'h12345000, 0, 7'b0100000); // lui x7
        vec_instr[4]  = 32'h010000EF; vec_ctrl[4]  = mk(1,  0, 16, 32'd16,       0, 7'b0100010); // jal x1,16
        vec_instr[5]  = 32'h00208463; vec_ctrl[5]  = mk(8,  1, 2,  32'd8,        0, 7'b0010100); // beq +8
        vec_instr[6]  = 32'hFE000EE3; vec_ctrl[6]  = mk(29, 0, 0,  32'hFFFFFFFC, 0, 7'b0010100); // beq -4
        vec_instr[7]  = 32'h403100B3; vec_ctrl[7]  = mk(1,  2, 3,  32'd0,        0, 7'b0110000); // sub
        vec_instr[8]  = 32'h403110B3; vec_ctrl[8]  = mk(1,  2, 3,  32'd0,        0, 7'b0010001); // bad funct7/funct3
        vec_instr[9]  = 32'h00508013; vec_ctrl[9]  = mk(0,  1, 5,  32'd5,        0, 7'b0000000); // addi x0 -> no write
        vec_instr[10] = 32'h00812281; vec_ctrl[10] = mk(5,  2, 8,  32'd0,        0, 7'b0000001); // low bits != 11
        vec_instr[11] = 32'hFFF24193; vec_ctrl[11] = mk(3,  4, 31, 32'hFFFFFFFF, 4, 7'b0100000); // xori x3,x4,-1
`ifdef DECODE_RV32M_EN
        vec_instr[12] = 32'h023100B3; vec_ctrl[12] = mk(1,  2, 3,  32'd0,        8, 7'b0110000); // mul
`else
        vec_instr[12] = 32'h023100B3; vec_ctrl[12] = mk(1,  2, 3,  32'd0,        0, 7'b0010001); // mul -> illegal
`endif

        // Reset state
        step();
        step();
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_cnt",       64'(illegal_cnt), 64'(0));
        check("rst_out_pc",    64'(out_pc),    64'(0));
        check("rst_out_ctrl",  64'(out_ctrl),  64'(0));
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Single-cycle decode of each vector, back to back
        for (int i = 0; i < NVEC; i++) begin
            drive(vec_instr[i], 32'h1000 + 32'(4 * i));
            step();
            check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(1));
            check($sformatf("vec%0d_pc", i),    64'(out_pc),    64'(32'h1000 + 32'(4 * i)));
            check($sformatf("vec%0d_ctrl", i),  64'(out_ctrl),  64'(vec_ctrl[i]));
            if (vec_ctrl[i].illegal) exp_cnt++;
        end
        in_valid = 1'b0;
        step();
        check("vec_drain_valid", 64'(out_valid),   64'(0));
        check("vec_cnt",         64'(illegal_cnt), 64'(exp_cnt));

        // Back-pressure: two captured, third held upstream, all in order
        out_ready = 1'b0;
        drive(vec_instr[2], 32'h200);
        step();
        check("bp_a_valid", 64'(out_valid), 64'(1));
        check("bp_a_ready", 64'(in_ready),  64'(1));
        drive(vec_instr[3], 32'h204);
        step();
        check("bp_b_ready", 64'(in_ready), 64'(0));
        check("bp_b_pc",    64'(out_pc),   64'(32'h200));
        drive(vec_instr[4], 32'h208);
        step();
        check("bp_hold_ready", 64'(in_ready), 64'(0));
        check("bp_hold_pc",    64'(out_pc),   64'(32'h200));
        check("bp_hold_ctrl",  64'(out_ctrl), 64'(vec_ctrl[2]));
        out_ready = 1'b1;
        step();
        check("bp_rel1_pc",    64'(out_pc),   64'(32'h204));
        check("bp_rel1_ctrl",  64'(out_ctrl), 64'(vec_ctrl[3]));
        check("bp_rel1_ready", 64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0;
        check("bp_rel2_valid", 64'(out_valid), 64'(1));
        check("bp_rel2_pc",    64'(out_pc),    64'(32'h208));
        check("bp_rel2_ctrl",  64'(out_ctrl),  64'(vec_ctrl[4]));
        step();
        check("bp_empty", 64'(out_valid), 64'(0));

        // Flush with both entries full and a third offered
        out_ready = 1'b0;
        drive(32'hFFFFFFFF, 32'h300);
        step();
        drive(32'hFFFFFFFF, 32'h304);
        step();
        check("fl_full_ready", 64'(in_ready), 64'(0));
        drive(32'h00812281, 32'h308);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", 64'(out_valid), 64'(0));
        check("fl_ready", 64'(in_ready),  64'(1));
        out_ready = 1'b1;
        step();
        step();
        check("fl_nothing_valid", 64'(out_valid),   64'(0));
        check("fl_cnt",           64'(illegal_cnt), 64'(exp_cnt));

        // Illegal counter saturation
        drive(32'hFFFFFFFF, 32'h400);
        for (int k = 0; k < 260; k++) begin
            step();
            if (k > 0 && exp_cnt < 255) exp_cnt++;
            check($sformatf("sat%0d_flags", k),
                  64'({out_ctrl.illegal, out_ctrl.regWrite, out_ctrl.memWrite,
                       out_ctrl.branch, out_ctrl.jump}), 64'(5'b10000));
            check($sformatf("sat%0d_cnt", k), 64'(illegal_cnt), 64'(exp_cnt));
        end
        in_valid = 1'b0;
        step();
        check("sat_final_cnt", 64'(illegal_cnt), 64'(255));

        // Reset mid-transfer drops everything
        out_ready = 1'b0;
        drive(vec_instr[0], 32'h500);
        step();
        drive(vec_instr[1], 32'h504);
        step();
        rst_n = 1'b0;
        step();
        in_valid = 1'b0;
        check("mrst_valid", 64'(out_valid),   64'(0));
        check("mrst_ready", 64'(in_ready),    64'(1));
        check("mrst_cnt",   64'(illegal_cnt), 64'(0));
        check("mrst_pc",    64'(out_pc),      64'(0));
        check("mrst_ctrl",  64'(out_ctrl),    64'(0));
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        check("mrst_after_valid", 64'(out_valid), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter PC_W, default 32: width of program-counter field carried with each instruction.
REQ-002 Parameter CNT_W, default 8: width of illegal-instruction counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  upstream offers instruction.
REQ-006 in_ready  output  1  stage can accept; transfer when in_valid && in_ready.
REQ-007 in_instr  input  32  RV32 instruction word.
REQ-008 in_pc  input  PC_W  instruction address.
REQ-009 flush  input  1  discard all buffered instructions.
REQ-010 out_valid  output  1  decoded bundle available.
REQ-011 out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
REQ-012 out_pc  output  PC_W  pc of presented instruction.
REQ-013 out_ctrl  output  ctrl_t  rd, rs1, rs2, imm[31:0], aluOp, memWrite, regWrite, aluSrc, memToReg, branch, jump, illegal.
REQ-014 illegal_cnt  output  CNT_W  count of illegal instructions delivered downstream.

Function
REQ-015 Decode SHALL cover lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, branch 1100011, lui 0110111, jal 1101111.
REQ-016 regWrite=1 for lw, R, I-ALU, lui, jal; forced 0 when rd==0.
REQ-017 memWrite=1 only for sw; memToReg=1 only for lw; branch=1 only for branch; jump=1 only for jal.
REQ-018 aluSrc=1 (operand 2 from rs2) for R-type and branch; 0 (from imm) otherwise.
REQ-019 imm SHALL be sign-extended per format I/S/B/U/J; R-type imm=0.
REQ-020 illegal=1 when instr[1:0]!=2'b11, opcode unlisted, or R-type funct7 not 0000000 (or 0100000 with funct3 000/101); illegal forces regWrite, memWrite, branch, jump to 0.
REQ-021 Latency exactly 1 cycle: instruction accepted in cycle N presented with out_valid=1 in cycle N+1 if output register empty or draining.
REQ-022 Storage SHALL be a 2-entry buffer (output register + skid register); in_ready = skid register empty, driven from a register, no combinational path from out_ready.
REQ-023 out_ctrl/out_pc SHALL be held stable while out_valid && !out_ready.
REQ-024 Simultaneous accept and deliver with output register full and skid empty: new bundle loads output register directly; no bubble.
REQ-025 When skid full, in_ready=0; on next delivery skid moves to output register and in_ready returns to 1 the following cycle.
REQ-026 flush SHALL clear both entries at that clock edge; input offered in flush cycle is discarded; out_valid=0 next cycle; illegal_cnt unaffected.
REQ-027 illegal_cnt increments by 1 on each delivery with illegal=1; saturates at 2^CNT_W-1.

Reset
REQ-028 When rst_n=0 at a clock edge: both entries empty, out_valid=0, in_ready=1 next cycle, illegal_cnt=0, out_pc=0, out_ctrl all fields 0.
REQ-029 Reset mid-transfer SHALL drop all in-flight instructions; no partial bundle delivered.

Configuration
REQ-030 Macro DECODE_RV32M_EN defined: R-type funct7 0000001 decodes as MUL/DIV family (aluOp codes 8-15, regWrite=1, illegal=0).
REQ-031 Macro undefined: funct7 0000001 SHALL be illegal; aluOp codes 8-15 never produced.

Structure
REQ-032 Package decode_pkg SHALL hold opcode constants, aluop_e enum (4-bit), and ctrl_t packed struct.
REQ-033 Combinational decode SHALL live in sub-module decode_logic (instr -> ctrl_t); decode_stage holds buffering and counter.

Verification
REQ-034 lw x5,8(x2) (0x00812283) then out_ready=1 -> next cycle regWrite=1, memToReg=1, aluSrc=0, rd=5, imm=8.
REQ-035 sw x5,-4(x2) (0xFE512E23) -> memWrite=1, regWrite=0, imm=0xFFFFFFFC.
REQ-036 out_ready=0 while 3 back-to-back valid instrs -> two captured, in_ready=0 after second, third held upstream; release -> delivered in order, no loss.
REQ-037 Instr 0xFFFFFFFF delivered 260 times with CNT_W=8 -> illegal=1 each, write enables 0, illegal_cnt saturates at 255.
REQ-038 Buffer full, flush=1 with in_valid=1 -> out_valid=0 next cycle, in_ready=1, none of the three instructions delivered.
REQ-039 mul x1,x2,x3 (0x023100B3) -> illegal=0, regWrite=1 with DECODE_RV32M_EN defined; illegal=1, regWrite=0 without.
